// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : disp_pkg
//  Description : Shared types and constants for the 4-digit 7-segment scan
//                controller: anode-off pattern, digit count, digit-index
//                type, scan state encoding and a one-hot digit helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    // All anodes released (anodes are active-low).
    localparam logic [3:0] AN_OFF     = 4'b1111;
    localparam int         NUM_DIGITS = 4;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // One-hot select for a digit position, bit k set for digit k.
    function automatic logic [3:0] digit_onehot(input digit_idx_t idx);
        return 4'b0001 << idx;
    endfunction

endpackage : disp_pkg
`default_nettype wire

// File: rtl/scan_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : scan_prescaler
//  Description : Free-running digit-slot prescaler. Counts while enabled,
//                is forced to zero by i_clr, and flags the last count of a
//                2^DIV_WIDTH-cycle slot on o_tc.
//  Ports       : clk    - system clock
//                rst_n  - synchronous active-low reset
//                i_clr  - synchronous clear (priority over i_en)
//                i_en   - count enable
//                o_tc   - terminal count: enabled and counter at all-ones
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_prescaler #(
    parameter int DIV_WIDTH = 17
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [DIV_WIDTH-1:0] r_div_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (i_clr) begin
            r_div_cnt <= '0;
        end else if (i_en) begin
            // Wraps to zero naturally after the terminal count.
            r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
        end
    end

    assign o_tc = i_en & (&r_div_cnt);

endmodule : scan_prescaler
`default_nettype wire

// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : disp_scan_ctrl
//  Description : Time-multiplexed scan controller for a 4-digit 7-segment
//                display. Shows one digit per slot through a shared decoder,
//                inserts an all-anodes-off dead time between digits, and
//                double-buffers new values so they are committed only at the
//                frame boundary (BLANK->SHOW with digit index wrapping 3->0).
//  Ports       : clk        - system clock
//                rst_n      - synchronous active-low reset
//                load       - strobe capturing data_in/point_in/en_in
//                data_in    - four hex digits, digit k = data_in[4k+3:4k]
//                point_in   - per-digit decimal point, 1 = lit
//                en_in      - per-digit enable, 0 keeps the anode off
//                hex        - nibble to decoder D3..D0
//                point      - decimal point to decoder
//                an         - active-low anodes, one-hot-low while showing
//                digit_idx  - digit currently scanned
//                frame_tick - one-cycle pulse on each commit of staged data
//  Revision    : 1.0 - initial release
// ============================================================================
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int DIV_WIDTH    = 17,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  point_in,
    input  logic [3:0]  en_in,
    output logic [3:0]  hex,
    output logic        point,
    output logic [3:0]  an,
    output logic [1:0]  digit_idx,
    output logic        frame_tick
);

    localparam int                BLANK_W      = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BLANK_W-1:0] c_BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);
    localparam digit_idx_t        c_LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    scan_state_t          r_state;
    digit_idx_t           r_idx;
    logic [BLANK_W-1:0]   r_blank_cnt;

    logic [15:0]          r_act_data;
    logic [3:0]           r_act_point;
    logic [3:0]           r_act_en;

    logic [15:0]          r_stg_data;
    logic [3:0]           r_stg_point;
    logic [3:0]           r_stg_en;
    logic                 r_pending;

    logic [3:0]           r_hex;
    logic                 r_point;
    logic [3:0]           r_an;
    logic                 r_frame_tick;

    // ------------------------------------------------------------------
    // Slot prescaler: runs only while a digit is shown
    // ------------------------------------------------------------------
    logic w_div_tc;

    scan_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (r_state == BLANK),
        .i_en  (r_state == SHOW),
        .o_tc  (w_div_tc)
    );

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    logic        w_show_end;
    logic        w_blank_end;
    logic        w_wrap;
    logic        w_commit;
    scan_state_t w_nxt_state;
    digit_idx_t  w_nxt_idx;
    digit_idx_t  w_look_idx;
    logic [15:0] w_nxt_data;
    logic [3:0]  w_nxt_point_v;
    logic [3:0]  w_nxt_en;
    logic [3:0]  w_nxt_hex;
    logic        w_nxt_point;
    logic [3:0]  w_nxt_an;

    always_comb begin
        w_show_end  = (r_state == SHOW)  && w_div_tc;
        w_blank_end = (r_state == BLANK) && (r_blank_cnt == c_BLANK_LAST);
        w_wrap      = w_blank_end && (r_idx == c_LAST_DIGIT);
        // A load arriving on the wrap edge bypasses staging and commits too.
        w_commit    = w_wrap && (load || r_pending);

        w_nxt_state = r_state;
        if (w_show_end) begin
            w_nxt_state = BLANK;
        end else if (w_blank_end) begin
            w_nxt_state = SHOW;
        end

        w_nxt_idx = w_blank_end ? (r_idx + 2'd1) : r_idx;

        w_nxt_data    = r_act_data;
        w_nxt_point_v = r_act_point;
        w_nxt_en      = r_act_en;
        if (w_wrap && load) begin
            w_nxt_data    = data_in;
            w_nxt_point_v = point_in;
            w_nxt_en      = en_in;
        end else if (w_wrap && r_pending) begin
            w_nxt_data    = r_stg_data;
            w_nxt_point_v = r_stg_point;
            w_nxt_en      = r_stg_en;
        end

        // While blanking, the decoder is pre-loaded with the digit that
        // will be shown next so the segments are settled before the anode
        // turns on.
        w_look_idx  = (w_nxt_state == SHOW) ? w_nxt_idx : (w_nxt_idx + 2'd1);
        w_nxt_hex   = w_nxt_data[{w_look_idx, 2'b00} +: 4];
        w_nxt_point = w_nxt_point_v[w_look_idx];
        w_nxt_an    = (w_nxt_state == SHOW) ? ~(digit_onehot(w_nxt_idx) & w_nxt_en) : AN_OFF;
    end

    // ------------------------------------------------------------------
    // Scan FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= BLANK;
            r_idx        <= c_LAST_DIGIT;
            r_blank_cnt  <= '0;
            r_act_data   <= '0;
            r_act_point  <= '0;
            r_act_en     <= '0;
            r_stg_data   <= '0;
            r_stg_point  <= '0;
            r_stg_en     <= '0;
            r_pending    <= 1'b0;
            r_hex        <= '0;
            r_point      <= 1'b0;
            r_an         <= AN_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_idx   <= w_nxt_idx;

            if (r_state == BLANK && !w_blank_end) begin
                r_blank_cnt <= r_blank_cnt + BLANK_W'(1);
            end else begin
                r_blank_cnt <= '0;
            end

            r_act_data  <= w_nxt_data;
            r_act_point <= w_nxt_point_v;
            r_act_en    <= w_nxt_en;

            if (load) begin
                r_stg_data  <= data_in;
                r_stg_point <= point_in;
                r_stg_en    <= en_in;
            end

            if (w_wrap) begin
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end

            r_hex        <= w_nxt_hex;
            r_point      <= w_nxt_point;
            r_an         <= w_nxt_an;
            r_frame_tick <= w_commit;
        end
    end

    assign hex        = r_hex;
    assign point      = r_point;
    assign an         = r_an;
    assign digit_idx  = r_idx;
    assign frame_tick = r_frame_tick;

endmodule : disp_scan_ctrl
`default_nettype wire

// File: tb/tb_disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_disp_scan_ctrl
//  Description : Directed self-checking bench for disp_scan_ctrl with
//                DIV_WIDTH=3, BLANK_CYCLES=2 (10-cycle slot, 40-cycle frame).
//                Cycle 0 is the first cycle after reset is released; the
//                first SHOW cycle of digit 0 in each frame is cycle 2+40n.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  point_in;
    logic [3:0]  en_in;
    logic [3:0]  hex;
    logic        point;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int checks;
    int failures;
    int cyc;
    int onehot_bad;

    disp_scan_ctrl #(
        .DIV_WIDTH    (3),
        .BLANK_CYCLES (2)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .data_in    (data_in),
        .point_in   (point_in),
        .en_in      (en_in),
        .hex        (hex),
        .point      (point),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // More than one anode low at once is always an error.
    initial onehot_bad = 0;
    always @(negedge clk) begin
        if ($countones(~an) > 1) onehot_bad++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // Present a one-cycle load during the current cycle.
    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
        load     = 1'b1;
        data_in  = d;
        point_in = p;
        en_in    = e;
        tick();
        load     = 1'b0;
    endtask

    // Run n cycles; count any cycle with an anode on or a frame tick.
    task automatic idle_run(input string tag, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (an !== 4'hF || frame_tick !== 1'b0) bad++;
        end
        check_val(tag, 16'(bad), 16'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        data_in  = '0;
        point_in = '0;
        en_in    = '0;

        // ---------------- Reset state, no load ----------------
        do_reset();
        check_val("rst_an",   16'(an),         16'hF);
        check_val("rst_hex",  16'(hex),        16'h0);
        check_val("rst_pt",   16'(point),      16'h0);
        check_val("rst_idx",  16'(digit_idx),  16'h3);
        check_val("rst_tick", 16'(frame_tick), 16'h0);
        idle_run("idle_dark", 100);

        // ---------------- Load before first frame ----------------
        do_reset();
        do_load(16'h1A2F, 4'b0010, 4'b1111);          // now cycle 1
        check_val("c1_an",   16'(an),         16'hF);
        check_val("c1_tick", 16'(frame_tick), 16'h0);
        run_to(2);
        check_val("c2_tick", 16'(frame_tick), 16'h1);
        check_val("c2_an",   16'(an),         16'hE);
        check_val("c2_hex",  16'(hex),        16'hF);
        check_val("c2_idx",  16'(digit_idx),  16'h0);
        run_to(3);
        check_val("c3_tick", 16'(frame_tick), 16'h0);
        run_to(9);
        check_val("c9_an",   16'(an),         16'hE);
        run_to(10);
        check_val("c10_an",  16'(an),         16'hF);
        check_val("c10_hex", 16'(hex),        16'h2);
        check_val("c10_idx", 16'(digit_idx),  16'h0);
        run_to(11);
        check_val("c11_an",  16'(an),         16'hF);
        run_to(12);
        check_val("c12_an",  16'(an),         16'hD);
        check_val("c12_hex", 16'(hex),        16'h2);
        check_val("c12_pt",  16'(point),      16'h1);
        check_val("c12_idx", 16'(digit_idx),  16'h1);

        // ---------------- Mid-frame load ----------------
        run_to(15);
        do_load(16'h0000, 4'b0000, 4'b1111);
        run_to(19);
        check_val("c19_an",  16'(an),         16'hD);
        run_to(22);
        check_val("c22_an",  16'(an),         16'hB);
        check_val("c22_hex", 16'(hex),        16'hA);
        check_val("c22_pt",  16'(point),      16'h0);
        run_to(32);
        check_val("c32_an",  16'(an),         16'h7);
        check_val("c32_hex", 16'(hex),        16'h1);
        run_to(41);
        check_val("c41_an",   16'(an),         16'hF);
        check_val("c41_tick", 16'(frame_tick), 16'h0);
        run_to(42);
        check_val("c42_tick", 16'(frame_tick), 16'h1);
        check_val("c42_an",   16'(an),         16'hE);
        check_val("c42_hex",  16'(hex),        16'h0);

        // ---------------- Overwrite, then load on commit edge ----------------
        run_to(50);
        do_load(16'h1111, 4'b0000, 4'b1111);
        run_to(60);
        do_load(16'h2222, 4'b0000, 4'b1111);
        run_to(81);
        check_val("c81_tick", 16'(frame_tick), 16'h0);
        run_to(82);
        check_val("c82_tick", 16'(frame_tick), 16'h1);
        check_val("c82_hex",  16'(hex),        16'h2);
        run_to(92);
        check_val("c92_an",   16'(an),         16'hD);
        check_val("c92_hex",  16'(hex),        16'h2);
        run_to(121);
        check_val("c121_hex", 16'(hex),        16'h2);
        do_load(16'h3333, 4'b0000, 4'b1111);       // load on the commit edge
        check_val("c122_tick", 16'(frame_tick), 16'h1);
        check_val("c122_hex",  16'(hex),        16'h3);
        check_val("c122_an",   16'(an),         16'hE);
        run_to(162);
        check_val("c162_tick", 16'(frame_tick), 16'h0);
        check_val("c162_hex",  16'(hex),        16'h3);

        // ---------------- Enable masking ----------------
        do_load(16'h4321, 4'b0000, 4'b0101);
        run_to(202);
        check_val("c202_tick", 16'(frame_tick), 16'h1);
        check_val("c202_an",   16'(an),         16'hE);
        check_val("c202_hex",  16'(hex),        16'h1);
        run_to(212);
        check_val("c212_an",   16'(an),         16'hF);
        check_val("c212_idx",  16'(digit_idx),  16'h1);
        run_to(222);
        check_val("c222_an",   16'(an),         16'hB);
        check_val("c222_hex",  16'(hex),        16'h3);
        run_to(232);
        check_val("c232_an",   16'(an),         16'hF);
        check_val("c232_idx",  16'(digit_idx),  16'h3);
        run_to(241);
        check_val("c241_an",   16'(an),         16'hF);
        run_to(242);
        check_val("c242_an",   16'(an),         16'hE);
        check_val("c242_tick", 16'(frame_tick), 16'h0);
        run_to(249);
        check_val("c249_an",   16'(an),         16'hE);
        run_to(250);
        check_val("c250_an",   16'(an),         16'hF);

        // ---------------- Reset mid-SHOW ----------------
        do_reset();
        do_load(16'h1A2F, 4'b0010, 4'b1111);
        run_to(20);
        do_load(16'h5555, 4'b0000, 4'b1111);       // pending, to be discarded
        run_to(25);
        check_val("r25_an", 16'(an), 16'hB);
        rst_n = 1'b0;
        tick();
        check_val("r26_an",   16'(an),         16'hF);
        check_val("r26_idx",  16'(digit_idx),  16'h3);
        check_val("r26_hex",  16'(hex),        16'h0);
        check_val("r26_tick", 16'(frame_tick), 16'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        cyc   = 0;
        idle_run("pend_lost", 90);

        // Restart timing matches the first load scenario.
        do_reset();
        do_load(16'h1A2F, 4'b0010, 4'b1111);
        run_to(2);
        check_val("rs2_tick", 16'(frame_tick), 16'h1);
        check_val("rs2_an",   16'(an),         16'hE);
        check_val("rs2_hex",  16'(hex),        16'hF);
        run_to(10);
        check_val("rs10_an",  16'(an),         16'hF);
        run_to(12);
        check_val("rs12_an",  16'(an),         16'hD);
        check_val("rs12_pt",  16'(point),      16'h1);

        check_val("an_onehot", 16'(onehot_bad), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_disp_scan_ctrl
`default_nettype wire
